// File: rtl/basys3_7seg_pkg.sv
// Shared definitions for the Basys3 7-segment capture block.
//   SEG_CODE   : active-high segment codes (gfedcba) for hex digits 0..F
//   seg_to_hex : reverse lookup, returns {valid, value}
//   pattern_t  : layout of the sampled {anode, segments} bus
package basys3_7seg_pkg;

  localparam int ANODE_W    = 4;
  localparam int SEG_W      = 7;
  localparam int PAT_W      = ANODE_W + SEG_W;
  localparam int NUM_DIGITS = 4;

  localparam logic [SEG_W-1:0] SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } hex_t;

  typedef struct packed {
    logic [ANODE_W-1:0] anode;
    logic [SEG_W-1:0]   segments;
  } pattern_t;

  // Reverse table lookup; valid stays 0 when the code is not a hex glyph.
  function automatic hex_t seg_to_hex(input logic [SEG_W-1:0] seg);
    hex_t r;
    r = '0;
    for (int v = 0; v < 16; v++) begin
      if (seg == SEG_CODE[v]) begin
        r.valid = 1'b1;
        r.value = 4'(v);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/basys3_7seg_filter.sv
// Input synchroniser and stability filter for the sampled display bus.
//   clk, rst : system clock, synchronous active-high reset
//   din      : raw asynchronous bus
//   pattern  : hold register, the last pattern seen on the synchronised bus
//   accept   : combinational, high on the single edge where a pattern has
//              been stable for STABLE_CYCLES samples
module basys3_7seg_filter
  import basys3_7seg_pkg::*;
#(
  parameter int WIDTH         = PAT_W,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pattern,
  output logic             accept
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sample;
  logic [CW-1:0]    cnt;

  // NOTE: every register here uses <= so all stages see pre-edge values;
  // blocking assignments would collapse the two synchroniser flops into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '1;
      sample  <= '1;
      pattern <= '1;
      cnt     <= '0;
    end else begin
      sync1  <= din;
      sample <= sync1;
      if (sample != pattern) begin
        pattern <= sample;
        cnt     <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The counter saturates at CNT_MAX, so it passes through CNT_PRE exactly
  // once per stable episode and accept cannot repeat.
  assign accept = (sample == pattern) && (cnt == CNT_PRE);

endmodule

// File: rtl/basys3_7seg_capture.sv
// Receive-side capture of the Basys3 multiplexed 7-segment bus.
// Rebuilds each digit's hex value and enable from the active-low bus.
//   clk_i, rst_i          : system clock, synchronous active-high reset
//   anode_i, segments_i   : active-low display bus (segments bit0=A..bit6=G)
//   digitN_o, digitN_en_o : last accepted value / digit lit with a valid code
//   update_o              : per-digit pulse when value or enable changes
//   code_err_o            : pulse, accepted single-digit pattern not a hex glyph
//   multi_anode_o         : pulse, accepted pattern drives several anodes
module basys3_7seg_capture
  import basys3_7seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ANODE_W-1:0]    anode_i,
  input  logic [SEG_W-1:0]      segments_i,
  output logic [3:0]            digit0_o,
  output logic [3:0]            digit1_o,
  output logic [3:0]            digit2_o,
  output logic [3:0]            digit3_o,
  output logic                  digit0_en_o,
  output logic                  digit1_en_o,
  output logic                  digit2_en_o,
  output logic                  digit3_en_o,
  output logic [NUM_DIGITS-1:0] update_o,
  output logic                  code_err_o,
  output logic                  multi_anode_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  pattern_t           pat;
  logic               accept;
  logic [ANODE_W-1:0] act_anode;
  logic [SEG_W-1:0]   act_seg;
  hex_t               hex;
  logic               one_hot;
  logic               blank;

  logic [3:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] en_q;
  logic [TW-1:0]         to_cnt  [NUM_DIGITS];

  basys3_7seg_filter #(
    .WIDTH         (PAT_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk     (clk_i),
    .rst     (rst_i),
    .din     ({anode_i, segments_i}),
    .pattern (pat),
    .accept  (accept)
  );

  // Decode the held pattern in active-high form.
  assign act_anode = ~pat.anode;
  assign act_seg   = ~pat.segments;
  assign hex       = seg_to_hex(act_seg);
  assign one_hot   = $onehot(act_anode);
  assign blank     = (act_seg == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digit_q[k] <= '0;
        to_cnt[k]  <= '0;
      end
      en_q          <= '0;
      update_o      <= '0;
      code_err_o    <= 1'b0;
      multi_anode_o <= 1'b0;
    end else begin
      // NOTE: update_o defaults to 0 here and individual bits are raised
      // below; the later non-blocking assignment to a bit takes effect.
      update_o      <= '0;
      code_err_o    <= accept && one_hot && !blank && !hex.valid;
      // Nonzero and not one-hot means two or more anodes are low.
      multi_anode_o <= accept && (act_anode != '0) && !one_hot;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (accept && one_hot && act_anode[k] && (blank || hex.valid)) begin
          // A lit scan of this digit restarts its timeout and wins over a
          // timeout expiring on the same edge.
          to_cnt[k] <= '0;
          if (blank) begin
            if (en_q[k]) begin
              en_q[k]     <= 1'b0;
              update_o[k] <= 1'b1;
            end
          end else begin
            digit_q[k] <= hex.value;
            en_q[k]    <= 1'b1;
            if (!en_q[k] || (digit_q[k] != hex.value)) update_o[k] <= 1'b1;
          end
        end else if (to_cnt[k] == TO_MAX) begin
          // Digit not scanned for TIMEOUT_CYCLES: blank it, keep its value.
          if (en_q[k]) begin
            en_q[k]     <= 1'b0;
            update_o[k] <= 1'b1;
          end
        end else begin
          to_cnt[k] <= to_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign digit0_o    = digit_q[0];
  assign digit1_o    = digit_q[1];
  assign digit2_o    = digit_q[2];
  assign digit3_o    = digit_q[3];
  assign digit0_en_o = en_q[0];
  assign digit1_en_o = en_q[1];
  assign digit2_en_o = en_q[2];
  assign digit3_en_o = en_q[3];

endmodule
